// File: rtl/vpll_reconfig_responder.sv
// vpll_reconfig_responder: Avalon-MM responder that streams a ROM profile into the video PLL and waits for lock
module vpll_reconfig_responder #(
  parameter int WIDX_W       = 4,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 16
) (
  input  logic                CLK_50M,
  input  logic                reset,
  input  logic                mgmt_write,
  input  logic [5:0]          mgmt_address,
  input  logic [31:0]         mgmt_writedata,
  output logic                mgmt_waitrequest,
  output logic [WIDX_W+1:0]   rom_addr,
  input  logic [38:0]         rom_data,
  output logic                pll_wr,
  output logic [5:0]          pll_addr,
  output logic [31:0]         pll_data,
  input  logic                pll_ack,
  input  logic                pll_locked,
  output logic                busy,
  output logic                done,
  output logic                lock_err
);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE);
  localparam logic [TW-1:0] TMO_MAX  = TW'(LOCK_TIMEOUT);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, LOCK, FIN} state_t;
  state_t state_q, state_d;
  logic [1:0]        prof_q, prof_d;
  logic [WIDX_W-1:0] idx_q, idx_d;
  logic              last_q, last_d;
  logic [5:0]        paddr_q, paddr_d;
  logic [31:0]       pdata_q, pdata_d;
  logic              wait_q, wait_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [SW-1:0]     stab_q, stab_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [1:0]        sync_q;
  logic              accept, start;
  logic              unused;
  assign unused = ^{mgmt_writedata[31:8], mgmt_writedata[5:0]};
  // waitrequest is low only in IDLE and FIN, so any accepted write lands there
  assign accept = mgmt_write && !wait_q;
  assign start  = accept && mgmt_address == 6'd2;
  always_comb begin
    state_d = state_q;
    prof_d  = (accept && mgmt_address == 6'd31) ? mgmt_writedata[7:6] : prof_q;
    idx_d   = idx_q;
    last_d  = last_q;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = start ? RD : IDLE;
        idx_d   = start ? '0 : idx_q;
        err_d   = start ? 1'b0 : err_q;
        wait_d  = start;
        busy_d  = start;
      end
      RD:   state_d = WAIT;
      WAIT: begin
        {last_d, paddr_d, pdata_d} = rom_data;
        state_d = WR;
      end
      WR: if (pll_ack) begin
        state_d = (last_q || &idx_q) ? LOCK : RD;
        idx_d   = (last_q || &idx_q) ? idx_q : idx_q + 1'b1;
        stab_d  = '0;
        tmo_d   = '0;
      end
      LOCK: begin
        stab_d = sync_q[1] ? stab_q + 1'b1 : '0;
        tmo_d  = tmo_q + 1'b1;
        if (stab_q == STAB_MAX || tmo_q == TMO_MAX) begin
          state_d = FIN;
          done_d  = 1'b1;
          wait_d  = 1'b0;
          busy_d  = 1'b0;
          err_d   = stab_q != STAB_MAX;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state_q <= IDLE;
      prof_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
      wait_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stab_q  <= '0;
      tmo_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      prof_q  <= prof_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      stab_q  <= stab_d;
      tmo_q   <= tmo_d;
      sync_q  <= {sync_q[0], pll_locked};
    end
  end
  assign mgmt_waitrequest = wait_q;
  assign rom_addr         = {prof_q, idx_q};
  assign pll_wr           = state_q == WR;
  assign pll_addr         = paddr_q;
  assign pll_data         = pdata_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign lock_err         = err_q;
endmodule
